// File: rtl/ej32_pkg.sv
// Shared types for the ej32 core.
// Memory sequencer sizes, states and byte-count helper.
package ej32_pkg;

  typedef enum logic [1:0] {
    MS_BYTE,
    MS_SHORT,
    MS_INT,
    MS_RSV
  } mem_size_t;

  typedef enum logic [2:0] {
    msIDLE,
    msLD,
    msLDW,
    msST,
    msDONE
  } ms_state_t;

  localparam int MS_MAXB = 4;

  // Index of the last byte in a burst (n-1); reserved size runs as a word.
  function automatic logic [1:0] ms_last(input mem_size_t s);
    case (s)
      MS_BYTE:  return 2'd0;
      MS_SHORT: return 2'd1;
      default:  return 2'(MS_MAXB - 1);
    endcase
  endfunction

endpackage

// File: rtl/ej32_mem_seq.sv
// Byte-serial load/store sequencer feeding the AU data byte stream.
// Big-endian bursts on a byte-wide synchronous RAM.
module ej32_mem_seq
  import ej32_pkg::*;
#(
  parameter int ASZ = 16,
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic           we,
  input  logic [1:0]     size,
  input  logic           sx,
  input  logic [ASZ-1:0] addr,
  input  logic [DSZ-1:0] wdata,
  output logic [ASZ-1:0] mem_a_o,
  output logic           mem_we_o,
  output logic [7:0]     mem_d_o,
  input  logic [7:0]     mem_q,
  output logic [7:0]     data_o,
  output logic           data_v_o,
  output logic [DSZ-1:0] rdata_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o
);

  ms_state_t      st_q, st_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [1:0]     last_q;
  logic           sx_q;
  logic [ASZ-1:0] addr_q;
  logic [DSZ-1:0] wdata_q;
  logic [DSZ-1:0] asm_q;
  logic [DSZ-1:0] rdata_q;
  logic [7:0]     dhold_q;
  logic           cap_q;
  logic           err_q;

  logic           accept;
  logic           at_last;
  logic [1:0]     bsel;
  logic [DSZ-1:0] ld_word;
  logic [DSZ-1:0] ld_ext;

  assign accept  = (st_q == msIDLE) && req;
  assign at_last = (cnt_q == last_q);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      msIDLE: begin
        if (req) begin
          st_d  = we ? msST : msLD;
          cnt_d = 2'd0;
        end
      end
      msLD: begin
        if (at_last) begin
          st_d  = msLDW;
          cnt_d = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      msLDW: st_d = msDONE;
      msST: begin
        if (at_last) begin
          st_d  = msDONE;
          cnt_d = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      msDONE:  st_d = msIDLE;
      default: st_d = msIDLE;
    endcase
  end

  assign ld_word = {asm_q[DSZ-9:0], mem_q};

  always_comb begin
    ld_ext = ld_word;
    unique case (1'b1)
      last_q == 2'd0: ld_ext = {{24{sx_q & ld_word[7]}}, ld_word[7:0]};
      last_q == 2'd1: ld_ext = {{16{sx_q & ld_word[15]}}, ld_word[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= msIDLE;
      cnt_q   <= 2'd0;
      last_q  <= 2'd0;
      sx_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
      dhold_q <= 8'h00;
      cap_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      cap_q <= (st_q == msLD);
      err_q <= accept && (mem_size_t'(size) == MS_RSV);
      if (accept) begin
        last_q  <= ms_last(mem_size_t'(size));
        sx_q    <= sx;
        addr_q  <= addr;
        wdata_q <= wdata;
        asm_q   <= '0;
        rdata_q <= '0;
      end
      if (cap_q) begin
        dhold_q <= mem_q;
        asm_q   <= ld_word;
      end
      if (st_q == msLDW) rdata_q <= ld_ext;
    end
  end

  // Store bytes go out MSB first.
  assign bsel     = last_q - cnt_q;
  assign mem_a_o  = addr_q + ASZ'(cnt_q);
  assign mem_we_o = (st_q == msST);
  assign mem_d_o  = mem_we_o ? wdata_q[{bsel, 3'b000} +: 8] : 8'h00;

  assign data_o   = cap_q ? mem_q : dhold_q;
  assign data_v_o = cap_q;
  assign rdata_o  = rdata_q;
  assign busy_o   = (st_q == msLD) || (st_q == msLDW) || (st_q == msST);
  assign done_o   = (st_q == msDONE);
  assign err_o    = err_q;

endmodule

// File: doc/ej32_mem_seq.md
Name: ej32_mem_seq

Overview:
Byte-serial memory load/store sequencer sitting directly upstream of the arithmetic unit's 8-bit `data` input.
- Turns one word/short/byte access request into a burst of single-byte accesses on the byte-wide synchronous RAM.
- On loads, streams each returned byte to the AU and assembles the big-endian (Java order) result.
- On stores, serialises TOS MSB-first onto the memory bus.

Parameters:
- ASZ, 16, byte address width.
- DSZ, 32, data word width (fixed at 32; other values unsupported).

Ports:
- clk  in  1  system clock (rising edge)
- rst  in  1  asynchronous, active-low reset
- req  in  1  start request; sampled only when busy_o=0
- we  in  1  0=load, 1=store
- size  in  2  0=byte, 1=short, 2=int, 3=reserved
- sx  in  1  load sign-extend enable (byte/short only)
- addr  in  ASZ  start byte address
- wdata  in  DSZ  store data (TOS)
- mem_a_o  out  ASZ  RAM byte address
- mem_we_o  out  1  RAM write strobe
- mem_d_o  out  8  RAM write byte
- mem_q  in  8  RAM read byte; valid one cycle after its address
- data_o  out  8  byte stream to AU `data`
- data_v_o  out  1  data_o valid
- rdata_o  out  DSZ  assembled load result
- busy_o  out  1  access in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse: reserved size seen

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; counter=0.
  - mem_a_o=0, mem_we_o=0, mem_d_o=0, data_o=0, data_v_o=0, rdata_o=0, busy_o=0, done_o=0, err_o=0.
  - Takes effect immediately, including mid-burst; mem_we_o drops in the same instant.
  - No partial rdata is retained.
- Byte count n: size 0 gives n=1, size 1 gives n=2, size 2 gives n=4.
- Size 3: handled as n=4; err_o pulses in the cycle after acceptance.
- Accept (IDLE, req=1 at edge E0):
  - Latch we, n, sx, addr, wdata.
  - Clear the assembly register; busy_o=1 from E0.
- States: IDLE, LD, LDW, ST, DONE.
  - IDLE -> LD (req & ~we) or ST (req & we).
  - LD: mem_a_o = addr+k for k=0..n-1, one per cycle; after k=n-1 go to LDW.
  - LDW: one cycle to capture the last byte; then DONE.
  - ST: mem_we_o=1 for n cycles.
    - Address addr+k, with mem_d_o = wdata[8*(n-1-k)+:8] (MSB first).
    - After the last byte go to DONE.
  - DONE: done_o=1, busy_o=0; then IDLE.
- Load byte capture:
  - In each cycle after an LD address cycle: data_o=mem_q, data_v_o=1.
  - Assembly register <= {reg[23:0], mem_q}.
- Load latency: n address cycles + 1 capture cycle + DONE. done_o is asserted in cycle n+2 after E0.
- Store latency: done_o is asserted in cycle n+1 after E0.
- rdata_o is valid in the DONE cycle and holds until the next accepted request.
  - n=1: sx ? sign-extend bit 7 : zero-extend.
  - n=2: sx ? sign-extend bit 15 : zero-extend.
  - n=4: sx ignored.
- Address arithmetic is modulo 2^ASZ: 0xFFFF+1 wraps to 0x0000 within a burst.
- req while busy_o=1 (LD/LDW/ST) is ignored. No queuing and no error flag.
- In DONE, busy_o=0 and req is NOT accepted. Back-to-back requests therefore have a one-cycle gap: accept in IDLE only.
- Outside LD capture cycles, data_v_o=0 and data_o holds its last value.
- mem_we_o is never asserted in LD/LDW/DONE/IDLE.

Decomposition:
- ej32_pkg gains:
  - `mem_size_t` enum {MS_BYTE, MS_SHORT, MS_INT, MS_RSV}
  - `ms_state_t` enum {msIDLE, msLD, msLDW, msST, msDONE}
  - constant MS_MAXB=4
- Single module; no sub-module needed. The extension/byte-select logic stays local combinational.

Test Plan:
- Reset mid-store: assert rst=0 during the 2nd ST cycle -> mem_we_o=0 at once, busy_o=0, a subsequent load works normally.
- Int load, RAM[0x0100..0x0103]=12 34 56 78, size=2 -> mem_a_o 0100..0103 on cycles 1-4, data_v_o cycles 2-5, done_o cycle 6, rdata_o=0x12345678.
- Byte load sx=1, RAM[0x0020]=0x9C -> rdata_o=0xFFFFFF9C, done_o cycle 3. Repeat with sx=0 -> 0x0000009C.
- Short store wdata=0xDEADBEEF, addr=0x0040 -> RAM[0x0040]=BE, RAM[0x0041]=EF, mem_we_o high exactly 2 cycles, done_o cycle 3.
- Wrap: int store addr=0xFFFE, wdata=0xA1B2C3D4 -> RAM[FFFE]=A1, [FFFF]=B2, [0000]=C3, [0001]=D4.
- req held high throughout an int load plus size=3 request -> second request accepted only in IDLE after DONE; size=3 yields 4-byte access and one err_o pulse.
